vga_effect_sequencer: RTL and testbench

//   Frame-synchronous controller for the VGA face/filter datapath.
//   - Drives vga_face's face_select and filter_select from BPM estimate, beat pulses and user switch.
//   - Monitors the vga_face Avalon-ST output; commits all changes only at end-of-frame, so no frame tears.
//   - Hysteretic CALM/ACTIVE/COOLDOWN state machine, beat-driven face rotation, multi-frame flash effect.

---
 rtl/vga_effect_sequencer.sv | 155 +++++++++++++++
 tb/tb_vga_effect_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_effect_sequencer.sv
// Frame-synchronous face/filter controller for vga_face: beat and BPM events
// are gathered during a frame and committed to the outputs only at end-of-frame.
module vga_effect_sequencer #(
  parameter int unsigned BPM_HI          = 120,
  parameter int unsigned BPM_LO          = 110,
  parameter int unsigned BEATS_PER_FACE  = 4,
  parameter int unsigned FLASH_FRAMES    = 3,
  parameter int unsigned COOLDOWN_FRAMES = 8,
  parameter int unsigned NUM_FACES       = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] final_bpm_estimate,
  input  logic        bpm_valid,
  input  logic        beat_pulse,
  input  logic        switch,
  input  logic        mon_valid,
  input  logic        mon_ready,
  input  logic        mon_eop,
  output logic [1:0]  face_select,
  output logic [3:0]  filter_select,
  output logic        active
);

  typedef enum logic [1:0] {ST_CALM, ST_ACTIVE, ST_COOLDOWN} state_t;

  localparam logic [3:0]  FILTER_NONE    = 4'b0000;
  localparam logic [3:0]  FILTER_INVERT  = 4'b0001;
  localparam logic [3:0]  FILTER_LIGHTEN = 4'b0010;
  localparam logic [3:0]  FILTER_DARKEN  = 4'b0100;
  localparam logic [15:0] BPM_HI_V       = 16'(BPM_HI);
  localparam logic [15:0] BPM_LO_V       = 16'(BPM_LO);
  localparam logic [15:0] BEAT_LAST      = 16'(BEATS_PER_FACE - 1);
  localparam logic [7:0]  FLASH_LOAD     = 8'(FLASH_FRAMES);
  localparam logic [7:0]  COOL_LAST      = 8'(COOLDOWN_FRAMES - 1);
  localparam logic [1:0]  FACE_LAST      = 2'(NUM_FACES - 1);

  state_t      state, state_next;
  logic [15:0] bpm_reg;
  logic [15:0] beat_cnt, beat_cnt_next;
  logic [7:0]  cool_cnt, cool_cnt_next;
  logic [7:0]  flash_cnt, flash_cnt_next;
  logic        flash_pend, flash_pend_next;
  logic        face_pend, face_pend_next;
  logic [1:0]  face_next;
  logic [3:0]  filter_next;
  logic        active_next;
  logic        frame_end;
  logic        beat;
  logic        beat_wrap;

  assign frame_end = mon_valid & mon_ready & mon_eop;
  assign beat      = beat_pulse & (state == ST_ACTIVE);
  assign beat_wrap = beat & (beat_cnt == BEAT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_CALM;
    else          state <= state_next;
  end

  // Hysteresis: the state only moves at frame boundaries, judged on the latched BPM.
  always_comb begin
    // NOTE: every variable gets a default first, so no path can infer a latch.
    state_next    = state;
    cool_cnt_next = cool_cnt;
    if (frame_end) begin
      unique case (state)
        ST_CALM: begin
          if (bpm_reg > BPM_HI_V) state_next = ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (bpm_reg < BPM_LO_V) begin
            state_next    = ST_COOLDOWN;
            cool_cnt_next = 8'd0;
          end
        end
        ST_COOLDOWN: begin
          if (bpm_reg > BPM_HI_V) begin
            state_next = ST_ACTIVE;
          end else if (bpm_reg >= BPM_LO_V) begin
            cool_cnt_next = 8'd0;
          end else if (cool_cnt == COOL_LAST) begin
            state_next    = ST_CALM;
            cool_cnt_next = 8'd0;
          end else begin
            cool_cnt_next = cool_cnt + 8'd1;
          end
        end
        default: state_next = ST_CALM;
      endcase
    end
  end

  always_comb begin
    beat_cnt_next   = beat_cnt;
    flash_cnt_next  = flash_cnt;
    flash_pend_next = flash_pend;
    face_pend_next  = face_pend;
    face_next       = face_select;
    filter_next     = filter_select;
    active_next     = active;

    if (beat) beat_cnt_next = beat_wrap ? 16'd0 : beat_cnt + 16'd1;

    if (frame_end) begin
      // Commit uses the flags as they stood before this cycle's beat.
      if (face_pend) face_next = (face_select == FACE_LAST) ? 2'd0 : face_select + 2'd1;
      if (flash_pend)            flash_cnt_next = FLASH_LOAD;
      else if (flash_cnt != 8'd0) flash_cnt_next = flash_cnt - 8'd1;
      flash_pend_next = 1'b0;
      face_pend_next  = 1'b0;

      if (state_next == ST_CALM) begin
        beat_cnt_next  = 16'd0;
        flash_cnt_next = 8'd0;
        filter_next    = FILTER_NONE;
        active_next    = 1'b0;
      end else begin
        active_next = 1'b1;
        if (flash_cnt_next != 8'd0) filter_next = switch ? FILTER_INVERT : FILTER_LIGHTEN;
        else                        filter_next = FILTER_DARKEN;
      end
    end

    // A beat arriving with frame_end re-arms its flag for the following frame.
    if (beat)      flash_pend_next = 1'b1;
    if (beat_wrap) face_pend_next  = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bpm_reg       <= 16'd0;
      beat_cnt      <= 16'd0;
      cool_cnt      <= 8'd0;
      flash_cnt     <= 8'd0;
      flash_pend    <= 1'b0;
      face_pend     <= 1'b0;
      face_select   <= 2'd0;
      filter_select <= FILTER_NONE;
      active        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (bpm_valid) bpm_reg <= final_bpm_estimate;
      beat_cnt      <= beat_cnt_next;
      cool_cnt      <= cool_cnt_next;
      flash_cnt     <= flash_cnt_next;
      flash_pend    <= flash_pend_next;
      face_pend     <= face_pend_next;
      face_select   <= face_next;
      filter_select <= filter_next;
      active        <= active_next;
    end
  end

endmodule

// File: tb/tb_vga_effect_sequencer.sv
// Self-checking bench for vga_effect_sequencer: directed scenarios followed by
// randomized traffic, all compared every cycle against a frame-level model.
module tb_vga_effect_sequencer;

  localparam int BPM_HI          = 120;
  localparam int BPM_LO          = 110;
  localparam int BEATS_PER_FACE  = 4;
  localparam int FLASH_FRAMES    = 3;
  localparam int COOLDOWN_FRAMES = 8;
  localparam int NUM_FACES       = 3;

  logic        clk;
  logic        reset_n;
  logic [15:0] final_bpm_estimate;
  logic        bpm_valid;
  logic        beat_pulse;
  logic        switch;
  logic        mon_valid;
  logic        mon_ready;
  logic        mon_eop;
  logic [1:0]  face_select;
  logic [3:0]  filter_select;
  logic        active;

  vga_effect_sequencer #(
    .BPM_HI(BPM_HI), .BPM_LO(BPM_LO), .BEATS_PER_FACE(BEATS_PER_FACE),
    .FLASH_FRAMES(FLASH_FRAMES), .COOLDOWN_FRAMES(COOLDOWN_FRAMES), .NUM_FACES(NUM_FACES)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .final_bpm_estimate(final_bpm_estimate), .bpm_valid(bpm_valid),
    .beat_pulse(beat_pulse), .switch(switch),
    .mon_valid(mon_valid), .mon_ready(mon_ready), .mon_eop(mon_eop),
    .face_select(face_select), .filter_select(filter_select), .active(active)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int   n_checks = 0;
  int   n_pass   = 0;
  logic sw_q     = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Reference model: mood, beat count, frames of flash left, calm frames seen.
  typedef enum {M_CALM, M_ACTIVE, M_COOL} mode_t;
  mode_t m_mode;
  int    m_bpm, m_beats, m_calm_frames, m_flash_left, m_face, m_filter;
  bit    m_flash_req, m_face_req, m_active;

  task automatic model_reset();
    m_mode = M_CALM;
    m_bpm = 0; m_beats = 0; m_calm_frames = 0; m_flash_left = 0;
    m_face = 0; m_filter = 0; m_active = 0;
    m_flash_req = 0; m_face_req = 0;
  endtask

  task automatic model_clock(input bit bv, input int bpm, input bit bt, input bit sw, input bit fe);
    bit    beat_ok;
    bit    wrap;
    mode_t nm;
    beat_ok = bt && (m_mode == M_ACTIVE);
    wrap    = 0;
    nm      = m_mode;
    if (beat_ok) begin
      m_beats++;
      if (m_beats == BEATS_PER_FACE) begin
        m_beats = 0;
        wrap    = 1;
      end
    end
    if (fe) begin
      if (m_mode == M_CALM) begin
        if (m_bpm > BPM_HI) nm = M_ACTIVE;
      end else if (m_mode == M_ACTIVE) begin
        if (m_bpm < BPM_LO) begin
          nm = M_COOL;
          m_calm_frames = 0;
        end
      end else begin
        if (m_bpm > BPM_HI) nm = M_ACTIVE;
        else if (m_bpm >= BPM_LO) m_calm_frames = 0;
        else begin
          m_calm_frames++;
          if (m_calm_frames == COOLDOWN_FRAMES) nm = M_CALM;
        end
      end
      if (m_face_req) m_face = (m_face + 1) % NUM_FACES;
      if (m_flash_req) m_flash_left = FLASH_FRAMES;
      else if (m_flash_left > 0) m_flash_left--;
      m_flash_req = 0;
      m_face_req  = 0;
      m_mode      = nm;
      if (nm == M_CALM) begin
        m_beats = 0; m_flash_left = 0; m_filter = 0; m_active = 0;
      end else begin
        m_active = 1;
        m_filter = (m_flash_left > 0) ? (sw ? 1 : 2) : 4;
      end
    end
    if (beat_ok) m_flash_req = 1;
    if (wrap)    m_face_req  = 1;
    if (bv)      m_bpm       = bpm;
  endtask

  task automatic compare_outputs(input string tag);
    check({tag, "_face"},   face_select,   m_face);
    check({tag, "_filter"}, filter_select, m_filter);
    check({tag, "_active"}, active,        m_active);
  endtask

  // One clock: drive at negedge, update model at posedge, compare at next negedge.
  task automatic step(input logic bv, input logic [15:0] bpm, input logic bt,
                      input logic mv, input logic mr, input logic me, input string tag);
    bpm_valid = bv; final_bpm_estimate = bpm; beat_pulse = bt; switch = sw_q;
    mon_valid = mv; mon_ready = mr; mon_eop = me;
    @(posedge clk);
    model_clock(bv, int'(bpm), bt, sw_q, mv & mr & me);
    @(negedge clk);
    compare_outputs(tag);
  endtask

  task automatic run_frame(input int idle, input int beats);
    for (int i = 0; i < idle; i++) step(1'b0, 16'd0, (i < beats), 1'b1, 1'b1, 1'b0, "mid");
    step(1'b0, 16'd0, 1'b0, 1'b1, 1'b1, 1'b1, "fe");
  endtask

  task automatic set_bpm(input logic [15:0] v);
    step(1'b1, v, 1'b0, 1'b1, 1'b1, 1'b0, "bpm");
  endtask

  task automatic pulse_reset();
    #2 reset_n = 1'b0;
    #1;
    check("rst_face",   face_select,   0);
    check("rst_filter", filter_select, 0);
    check("rst_active", active,        0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; final_bpm_estimate = 16'd0; bpm_valid = 1'b0; beat_pulse = 1'b0;
    switch = 1'b0; mon_valid = 1'b0; mon_ready = 1'b0; mon_eop = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_face",   face_select,   0);
    check("reset_filter", filter_select, 0);
    check("reset_active", active,        0);
    reset_n = 1'b1;

    // Calm BPM keeps everything idle.
    set_bpm(16'd100);
    repeat (3) begin
      run_frame(4, 0);
      check("t1_face", face_select, 0);
      check("t1_filter", filter_select, 0);
      check("t1_active", active, 0);
    end

    // Enter ACTIVE, then a single beat flashes invert for three frames.
    set_bpm(16'd130);
    run_frame(3, 0);
    check("t2_active", active, 1);
    check("t2_filter", filter_select, 4'b0100);
    sw_q = 1'b1;
    run_frame(5, 1);
    check("t2_flash1", filter_select, 4'b0001);
    run_frame(5, 0);
    check("t2_flash2", filter_select, 4'b0001);
    run_frame(5, 0);
    check("t2_flash3", filter_select, 4'b0001);
    run_frame(5, 0);
    check("t2_dark", filter_select, 4'b0100);

    // Face rotation with wrap, starting from a clean beat count.
    pulse_reset();
    set_bpm(16'd130);
    run_frame(3, 0);
    for (int k = 1; k <= 3; k++) begin
      run_frame(6, 2);
      check("t3_hold", face_select, (k - 1) % NUM_FACES);
      run_frame(6, 2);
      check("t3_adv", face_select, k % NUM_FACES);
    end

    // Cooldown runs eight calm frames before returning to CALM.
    set_bpm(16'd105);
    run_frame(3, 0);
    check("t4_cool", active, 1);
    for (int k = 0; k < COOLDOWN_FRAMES - 1; k++) begin
      run_frame(3, 0);
      check("t4_cool_hold", active, 1);
    end
    run_frame(3, 0);
    check("t4_calm_active", active, 0);
    check("t4_calm_filter", filter_select, 0);
    set_bpm(16'd130);
    run_frame(3, 0);
    set_bpm(16'd105);
    run_frame(3, 0);
    repeat (3) run_frame(3, 0);
    set_bpm(16'd125);
    run_frame(3, 0);
    check("t4_reactive", active, 1);
    check("t4_reactive_filter", filter_select, 4'b0100);

    // Beat coincident with frame_end flashes only from the next frame_end.
    repeat (4) run_frame(3, 0);
    sw_q = 1'b0;
    step(1'b0, 16'd0, 1'b1, 1'b1, 1'b1, 1'b1, "t5_fe_beat");
    check("t5_no_flash", filter_select, 4'b0100);
    run_frame(5, 0);
    check("t5_flash", filter_select, 4'b0010);

    // Stalled eop and switch toggles leave committed outputs alone; reset mid-frame.
    sw_q = 1'b1;
    repeat (5) step(1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b1, "t6_stall");
    step(1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b1, "t6_noval");
    check("t6_filter_held", filter_select, 4'b0010);
    check("t6_active_held", active, 1);
    step(1'b0, 16'd0, 1'b0, 1'b1, 1'b1, 1'b0, "t6_mid");
    pulse_reset();

    // Randomized traffic.
    for (int n = 0; n < 6000; n++) begin
      if ($urandom_range(0, 29) == 0) sw_q = ~sw_q;
      if ($urandom_range(0, 1499) == 0) pulse_reset();
      else step(($urandom_range(0, 39) == 0), 16'($urandom_range(95, 140)),
                ($urandom_range(0, 14) == 0), ($urandom_range(0, 9) < 7),
                ($urandom_range(0, 9) < 7), ($urandom_range(0, 11) == 0), "rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
